// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings, FSM states and helpers for mem_access_unit
package mem_access_pkg;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = 3;

  // Reserved size is never legal; word needs 4-byte, half needs 2-byte alignment
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_WORD: is_misaligned = (lane != 2'b00);
      SZ_HALF: is_misaligned = lane[0];
      SZ_BYTE: is_misaligned = 1'b0;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_merge.sv
// rtl/mem_access_unit_merge.sv - byte_lane_merge: little-endian load extraction and store merge
module byte_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and half-word out of the memory word
  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  // Widen the selected lane to 32 bits, zero- or sign-extended
  always_comb begin
    o_load_data = i_word;
    case (i_size)
      SZ_HALF: o_load_data = {{16{i_sign_ext & w_half[15]}}, w_half};
      SZ_BYTE: o_load_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      default: o_load_data = i_word;
    endcase
  end

  // Overwrite only the addressed lane(s); untouched bytes come from the read word
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_HALF: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      SZ_BYTE: begin
        case (i_lane)
          2'd0: o_merged[7:0]   = i_wdata[7:0];
          2'd1: o_merged[15:8]  = i_wdata[7:0];
          2'd2: o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer to word memory; MEM_ACCESS_SIGNEXT_EN enables signed loads
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef MEM_ACCESS_SIGNEXT_EN
  localparam logic SIGNEXT_EN = 1'b1;
`else
  localparam logic SIGNEXT_EN = 1'b0;
`endif

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT);

  logic [1:0]           r_state;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_op;
  logic [1:0]           r_size;
  logic [1:0]           r_lane;
  logic                 r_sign_ext;
  logic [31:0]          r_wdata;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic [31:0]          r_rdata;
  logic                 r_busy;
  logic                 r_err;

  logic                 w_misaligned;
  logic                 w_sext;
  logic [31:0]          w_load_data;
  logic [31:0]          w_merged;

  assign w_misaligned = is_misaligned(size, addr[1:0]);
  assign w_sext       = r_sign_ext & SIGNEXT_EN;

  byte_lane_merge u_merge (
    .i_word      (mem_rdata),
    .i_wdata     (r_wdata),
    .i_lane      (r_lane),
    .i_size      (r_size),
    .i_sign_ext  (w_sext),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // Request capture, latency counting and state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_LOAD;
      r_size      <= SZ_WORD;
      r_lane      <= 2'b00;
      r_sign_ext  <= 1'b0;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_busy) begin
            // a misaligned request waits one cycle here so it reports like any other
            r_state <= ST_DONE;
          end else if (start) begin
            r_op       <= op;
            r_size     <= size;
            r_lane     <= addr[1:0];
            r_sign_ext <= sign_ext;
            r_wdata    <= wdata;
            r_mem_addr <= {addr[31:2], 2'b00};
            r_busy     <= 1'b1;
            r_err      <= w_misaligned;
            r_cnt      <= LAT_INIT;
            if (w_misaligned) begin
              r_state <= ST_IDLE;
            end else if (op == OP_STORE && size == SZ_WORD) begin
              r_mem_wdata <= wdata;
              r_state     <= ST_WRITE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_cnt == '0) begin
            if (r_op == OP_LOAD) begin
              r_rdata <= w_load_data;
              r_state <= ST_DONE;
            end else begin
              r_mem_wdata <= w_merged;
              r_state     <= ST_WRITE;
            end
          end else begin
            r_cnt <= r_cnt - LAT_CNT_W'(1);
          end
        end
        ST_WRITE: r_state <= ST_DONE;
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wr    = (r_state == ST_WRITE);
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign done      = (r_state == ST_DONE);
  assign err       = (r_state == ST_DONE) & r_err;

endmodule
